// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, access size
// codes and the alignment rule applied to data requests.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GNT_D  = 3'd1,
        ST_GNT_I  = 3'd2,
        ST_DONE_D = 3'd3,
        ST_DONE_I = 3'd4,
        ST_ERR_D  = 3'd5
    } arb_state_e;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int STARVE_W = 4;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            SZ_HALF: misaligned = addr_lo[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
// at_limit tells the arbiter to hand the next grant to fetch.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data wins
// ties unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [31:0]         if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [1:0]          dm_size,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [31:0]         dm_wdata,
    output logic [31:0]         dm_rdata,
    output logic                dm_valid,
    output logic                dm_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [1:0]          mem_size,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_ready,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                busy,
    output arb_state_e          dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    // Handshake: requesters hold *_req level until their one-cycle *_valid
    // pulse; toward memory mem_req and its fields stay constant until the
    // cycle mem_ready is seen, and that cycle completes the access.

    arb_state_e          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         dm_rdata_q, dm_rdata_d;
    logic                cnt_inc, cnt_clr, at_limit;

    arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .cnt      (dbg_starve_cnt),
        .at_limit (at_limit)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dm_req && misaligned(dm_size, dm_addr[1:0])) begin
                    state_d = ST_ERR_D;
                end else if (dm_req && !(if_req && at_limit)) begin
                    state_d     = ST_GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_size_d  = dm_size;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_inc     = if_req;
                end else if (if_req) begin
                    state_d     = ST_GNT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_size_d  = SZ_WORD;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    cnt_clr     = 1'b1;
                end
            end
            ST_GNT_D: begin
                if (mem_ready) begin
                    state_d   = ST_DONE_D;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            ST_GNT_I: begin
                if (mem_ready) begin
                    state_d    = ST_DONE_I;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                end
            end
            // Completion states never arbitrate, so a still-high req is not re-granted.
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = (state_q == ST_DONE_I);
    assign dm_valid  = (state_q == ST_DONE_D) || (state_q == ST_ERR_D);
    assign dm_err    = (state_q == ST_ERR_D);
    assign busy      = (state_q != ST_IDLE);
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = dm_req && !dm_valid;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: arbitration vector table, directed multi-cycle
// sequences, and a randomized run against a transaction-timing reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                if_req;
    logic [AW-1:0]       if_addr;
    logic [31:0]         if_rdata;
    logic                if_valid;
    logic                dm_req, dm_we;
    logic [1:0]          dm_size;
    logic [AW-1:0]       dm_addr;
    logic [31:0]         dm_wdata, dm_rdata;
    logic                dm_valid, dm_err;
    logic                mem_req, mem_we;
    logic [1:0]          mem_size;
    logic [AW-1:0]       mem_addr;
    logic [31:0]         mem_wdata, mem_rdata;
    logic                mem_ready;
    logic                stall_if, stall_mem, busy;
    arb_state_e          dbg_state;
    logic [STARVE_W-1:0] dbg_starve_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_size   = 2'b00;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Alignment rule written as address arithmetic.
    function automatic bit mis_ref(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd0 && (a % 4) != 0) || (sz == 2'd1 && (a % 2) != 0);
    endfunction

    typedef struct {
        logic       dm_req, if_req, dm_we;
        logic [1:0] dm_size, addr_lo;
        logic       exp_err, exp_gnt_d, exp_gnt_i;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic dr, input logic ir, input logic we,
                                input logic [1:0] sz, input logic [1:0] lo,
                                input logic e, input logic gd, input logic gi);
        vec_t v;
        v.dm_req = dr; v.if_req = ir; v.dm_we = we; v.dm_size = sz; v.addr_lo = lo;
        v.exp_err = e; v.exp_gnt_d = gd; v.exp_gnt_i = gi;
        return v;
    endfunction

    // Random-run reference state: one in-flight transaction described by its timing.
    int          free_c, t_start, t_ready, t_done, kind, starve;
    logic [31:0] t_addr, t_wdata, t_cap, m_if_rd, m_dm_rd;
    logic        t_we;
    logic [1:0]  t_size;
    bit          if_pend, dm_pend;
    logic        e_ifv, e_dmv, e_err, e_mreq, e_busy;
    logic [31:0] ia, da, wd, rd;
    int          dgrants;
    bit          got_if;
    vec_t        v;

    initial begin
        vecs[0] = mk(0, 1, 0, 2'd0, 2'd0, 0, 0, 1);
        vecs[1] = mk(1, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        vecs[2] = mk(1, 0, 1, 2'd2, 2'd3, 0, 1, 0);
        vecs[3] = mk(1, 0, 0, 2'd1, 2'd1, 1, 0, 0);
        vecs[4] = mk(1, 0, 1, 2'd1, 2'd2, 0, 1, 0);
        vecs[5] = mk(1, 0, 0, 2'd0, 2'd2, 1, 0, 0);
        vecs[6] = mk(1, 0, 0, 2'd3, 2'd0, 1, 0, 0);
        vecs[7] = mk(1, 1, 0, 2'd0, 2'd0, 0, 1, 0);
        vecs[8] = mk(1, 1, 1, 2'd0, 2'd1, 1, 0, 0);
        vecs[9] = mk(0, 0, 0, 2'd0, 2'd0, 0, 0, 0);

        // Reset state
        do_reset();
        settle();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_dm_valid", dm_valid, 0);
        chk("rst_dm_err", dm_err, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_starve", 32'(dbg_starve_cnt), 0);
        next_cycle();

        // Arbitration vector table, each from a fresh reset
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            do_reset();
            ia = $urandom & 32'hFFFF_FFFC;
            da = ($urandom & 32'hFFFF_FFFC) | {30'd0, v.addr_lo};
            wd = $urandom;
            rd = $urandom;
            if_req = v.if_req; if_addr = ia;
            dm_req = v.dm_req; dm_we = v.dm_we; dm_size = v.dm_size;
            dm_addr = da; dm_wdata = wd;
            settle();
            chk($sformatf("vec%0d_c0_stall_if", i), stall_if, v.if_req);
            chk($sformatf("vec%0d_c0_stall_mem", i), stall_mem, v.dm_req);
            chk($sformatf("vec%0d_c0_busy", i), busy, 0);
            next_cycle();
            mem_ready = v.exp_gnt_d | v.exp_gnt_i;
            mem_rdata = rd;
            settle();
            chk($sformatf("vec%0d_c1_mem_req", i), mem_req, v.exp_gnt_d | v.exp_gnt_i);
            if (v.exp_gnt_d | v.exp_gnt_i) begin
                chk($sformatf("vec%0d_c1_mem_addr", i), mem_addr, v.exp_gnt_d ? da : ia);
                chk($sformatf("vec%0d_c1_mem_we", i), mem_we, v.exp_gnt_d & v.dm_we);
                chk($sformatf("vec%0d_c1_mem_size", i), mem_size, v.exp_gnt_d ? v.dm_size : 2'd0);
                if (v.exp_gnt_d && v.dm_we)
                    chk($sformatf("vec%0d_c1_mem_wdata", i), mem_wdata, wd);
            end
            chk($sformatf("vec%0d_c1_dm_valid", i), dm_valid, v.exp_err);
            chk($sformatf("vec%0d_c1_dm_err", i), dm_err, v.exp_err);
            chk($sformatf("vec%0d_c1_busy", i), busy, v.exp_err | v.exp_gnt_d | v.exp_gnt_i);
            next_cycle();
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            settle();
            chk($sformatf("vec%0d_c2_if_valid", i), if_valid, v.exp_gnt_i);
            chk($sformatf("vec%0d_c2_dm_valid", i), dm_valid, v.exp_gnt_d);
            chk($sformatf("vec%0d_c2_dm_err", i), dm_err, 0);
            chk($sformatf("vec%0d_c2_mem_req", i), mem_req, 0);
            chk($sformatf("vec%0d_c2_stall_mem", i), stall_mem, v.dm_req & ~v.exp_gnt_d);
            chk($sformatf("vec%0d_c2_if_rdata", i), if_rdata, v.exp_gnt_i ? rd : 32'd0);
            chk($sformatf("vec%0d_c2_dm_rdata", i), dm_rdata, (v.exp_gnt_d && !v.dm_we) ? rd : 32'd0);
            if (v.exp_err)
                chk($sformatf("vec%0d_c2_state", i), 32'(dbg_state), 32'(ST_IDLE));
            next_cycle();
            idle_inputs();
        end

        // Single fetch at 0x40
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        settle();
        chk("fetch_c0_stall_if", stall_if, 1);
        chk("fetch_c0_mem_req", mem_req, 0);
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
        settle();
        chk("fetch_c1_mem_req", mem_req, 1);
        chk("fetch_c1_mem_addr", mem_addr, 32'h40);
        chk("fetch_c1_mem_we", mem_we, 0);
        chk("fetch_c1_stall_if", stall_if, 1);
        next_cycle();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("fetch_c2_if_valid", if_valid, 1);
        chk("fetch_c2_if_rdata", if_rdata, 32'h2008_0005);
        chk("fetch_c2_stall_if", stall_if, 0);
        next_cycle();
        if_req = 1'b0;
        settle();
        chk("fetch_c3_if_valid", if_valid, 0);
        chk("fetch_c3_busy", busy, 0);
        chk("fetch_c3_if_rdata_hold", if_rdata, 32'h2008_0005);
        next_cycle();

        // Collision: data first, fetch three cycles later
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_1000;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = SZ_WORD; dm_addr = 32'h0000_0100;
        settle();
        chk("coll_c0_stall_if", stall_if, 1);
        chk("coll_c0_stall_mem", stall_mem, 1);
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        settle();
        chk("coll_c1_mem_addr", mem_addr, 32'h100);
        next_cycle();
        mem_ready = 1'b0;
        settle();
        chk("coll_c2_dm_valid", dm_valid, 1);
        chk("coll_c2_if_valid", if_valid, 0);
        chk("coll_c2_dm_rdata", dm_rdata, 32'h1111_2222);
        next_cycle();
        dm_req = 1'b0;
        settle();
        chk("coll_c3_mem_req", mem_req, 0);
        chk("coll_c3_busy", busy, 0);
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
        settle();
        chk("coll_c4_mem_req", mem_req, 1);
        chk("coll_c4_mem_addr", mem_addr, 32'h1000);
        next_cycle();
        mem_ready = 1'b0;
        settle();
        chk("coll_c5_if_valid", if_valid, 1);
        chk("coll_c5_if_rdata", if_rdata, 32'h3333_4444);
        chk("coll_c5_starve", 32'(dbg_starve_cnt), 0);
        next_cycle();
        idle_inputs();

        // Starvation guard: fetch held, data re-requested back to back
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_2000;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = SZ_WORD; dm_addr = 32'h0000_0300;
        dgrants = 0;
        got_if  = 1'b0;
        for (int c = 0; c < 200 && !got_if; c++) begin
            mem_ready = mem_req;
            mem_rdata = 32'(c);
            if (mem_req && mem_addr == 32'h300) dgrants++;
            settle();
            if (if_valid) got_if = 1'b1;
            next_cycle();
        end
        chk("starve_fetch_served", 32'(got_if), 1);
        chk("starve_data_grants", 32'(dgrants), LIMIT);
        idle_inputs();
        settle();
        chk("starve_cnt_cleared", 32'(dbg_starve_cnt), 0);
        next_cycle();

        // Byte store with five wait states
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_size = SZ_BYTE; dm_addr = 32'h0000_0203; dm_wdata = 32'hAB;
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            mem_ready = (k == 5);
            mem_rdata = 32'hDEAD_BEEF;
            settle();
            chk($sformatf("wait%0d_mem_req", k), mem_req, 1);
            chk($sformatf("wait%0d_mem_addr", k), mem_addr, 32'h203);
            chk($sformatf("wait%0d_mem_wdata", k), mem_wdata, 32'hAB);
            chk($sformatf("wait%0d_mem_size", k), mem_size, 2'b10);
            chk($sformatf("wait%0d_mem_we", k), mem_we, 1);
            chk($sformatf("wait%0d_dm_valid", k), dm_valid, 0);
            next_cycle();
        end
        mem_ready = 1'b0;
        settle();
        chk("wait_done_dm_valid", dm_valid, 1);
        chk("wait_done_dm_err", dm_err, 0);
        chk("wait_done_dm_rdata", dm_rdata, 0);
        chk("wait_done_mem_req", mem_req, 0);
        next_cycle();
        idle_inputs();

        // Reset while a fetch waits on memory
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0500;
        next_cycle();
        settle();
        chk("rstmid_gnt_mem_req", mem_req, 1);
        chk("rstmid_gnt_state", 32'(dbg_state), 32'(ST_GNT_I));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_req = 1'b0;
        settle();
        chk("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_starve", 32'(dbg_starve_cnt), 0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            chk($sformatf("rstmid_if_valid%0d", k), if_valid, 0);
        end
        next_cycle();

        // Randomized traffic against the timing reference model
        do_reset();
        free_c = 0; kind = 0; t_start = -10; t_ready = -10; t_done = -10;
        starve = 0; m_if_rd = 0; m_dm_rd = 0; if_pend = 0; dm_pend = 0; t_cap = 0;
        for (int c = 0; c < 800; c++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                int sz;
                dm_pend = 1; dm_req = 1'b1;
                dm_we = 1'($urandom_range(0, 1));
                sz = $urandom_range(0, 9);
                dm_size = (sz < 5) ? 2'd0 : (sz < 7) ? 2'd1 : (sz < 9) ? 2'd2 : 2'd3;
                dm_addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
                dm_wdata = $urandom;
            end
            mem_ready = (kind == 1 || kind == 2) && c == t_ready;
            mem_rdata = $urandom;
            if (mem_ready) t_cap = mem_rdata;
            e_mreq = (kind == 1 || kind == 2) && c > t_start && c <= t_ready;
            e_ifv  = (kind == 2) && c == t_done;
            e_dmv  = (kind == 1 || kind == 3) && c == t_done;
            e_err  = (kind == 3) && c == t_done;
            e_busy = (kind != 0) && c > t_start && c <= t_done;
            if (e_ifv) m_if_rd = t_cap;
            if (kind == 1 && !t_we && c == t_done) m_dm_rd = t_cap;
            settle();
            chk("rnd_mem_req", mem_req, e_mreq);
            chk("rnd_if_valid", if_valid, e_ifv);
            chk("rnd_dm_valid", dm_valid, e_dmv);
            chk("rnd_dm_err", dm_err, e_err);
            chk("rnd_busy", busy, e_busy);
            chk("rnd_stall_if", stall_if, if_req & ~e_ifv);
            chk("rnd_stall_mem", stall_mem, dm_req & ~e_dmv);
            chk("rnd_if_rdata", if_rdata, m_if_rd);
            chk("rnd_dm_rdata", dm_rdata, m_dm_rd);
            chk("rnd_starve", 32'(dbg_starve_cnt), 32'(starve));
            if (e_mreq) begin
                chk("rnd_mem_addr", mem_addr, t_addr);
                chk("rnd_mem_we", mem_we, t_we);
                chk("rnd_mem_size", mem_size, t_size);
                if (t_we) chk("rnd_mem_wdata", mem_wdata, t_wdata);
            end
            if (c >= free_c && (dm_req || if_req)) begin
                t_start = c;
                if (dm_req && mis_ref(dm_size, dm_addr)) begin
                    kind = 3; t_done = c + 1;
                end else if (dm_req && !(if_req && starve == LIMIT)) begin
                    kind = 1; t_addr = dm_addr; t_we = dm_we; t_size = dm_size; t_wdata = dm_wdata;
                    t_ready = c + 1 + $urandom_range(0, 3); t_done = t_ready + 1;
                    if (if_req && starve < 15) starve++;
                end else begin
                    kind = 2; t_addr = if_addr; t_we = 1'b0; t_size = 2'd0; t_wdata = 0;
                    t_ready = c + 1 + $urandom_range(0, 3); t_done = t_ready + 1;
                    starve = 0;
                end
                free_c = t_done + 1;
            end
            next_cycle();
            if (e_ifv) begin if_pend = 0; if_req = 1'b0; end
            if (e_dmv) begin dm_pend = 0; dm_req = 1'b0; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
